// File: rtl/mi32_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mi32_resp_pkg
// Description : Shared types and constants for the MI32 responder: bus widths,
//               the data returned on an address miss, the wait-state FSM
//               state encoding and the read-pipeline stage record.
// Revision    : 1.0 - initial release
// ============================================================================
package mi32_resp_pkg;

  localparam int MI32_DATA_W = 32;
  localparam int MI32_BE_W   = 4;

  localparam logic [MI32_DATA_W-1:0] MI32_MISS_DATA = 32'h0;

  // Wait-state FSM encoding (only instantiated with MI32_RESP_WAIT_EN)
  typedef enum logic [0:0] {
    WS_IDLE = 1'b0,
    WS_WAIT = 1'b1
  } wait_state_e;

  // One slot of the fixed-latency read return pipeline
  typedef struct packed {
    logic                   vld;
    logic [MI32_DATA_W-1:0] data;
  } rd_stage_t;

endpackage : mi32_resp_pkg
`default_nettype wire

// File: rtl/mi32_resp_rdpipe.sv
`default_nettype none
// ============================================================================
// Module      : mi32_resp_rdpipe
// Description : READ_LATENCY-deep shift register carrying read results from
//               acceptance to the DRDY/DRD outputs. No backpressure: one entry
//               enters and one leaves every cycle.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset, empties pipeline
//               push_vld   - a read was accepted on this edge
//               push_data  - word sampled for that read
//               drdy       - final stage valid
//               drd        - final stage data (zero when not valid)
// Revision    : 1.0 - initial release
// ============================================================================
module mi32_resp_rdpipe
  import mi32_resp_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [MI32_DATA_W-1:0] push_data,
  output logic                   drdy,
  output logic [MI32_DATA_W-1:0] drd
);

  rd_stage_t stage_q [READ_LATENCY];
  rd_stage_t stage_d [READ_LATENCY];

  always_comb begin
    // Empty slots carry zero data so DRD reads 0 whenever DRDY is low.
    stage_d[0].vld  = push_vld;
    stage_d[0].data = push_vld ? push_data : MI32_MISS_DATA;
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign drdy = stage_q[READ_LATENCY-1].vld;
  assign drd  = stage_q[READ_LATENCY-1].data;

endmodule : mi32_resp_rdpipe
`default_nettype wire

// File: rtl/mi32_responder.sv
`default_nettype none
// ============================================================================
// Module      : mi32_responder
// Description : MI32 target with a byte-writable array of 2^ADDR_BITS words at
//               BASE_ADDR. Reads return in order after READ_LATENCY cycles;
//               misses read as zero and miss writes are dropped.
//               Optional macro MI32_RESP_WAIT_EN builds a wait-state FSM that
//               withholds ARDY for WAIT_STATES cycles per request.
// Ports       : CLK    - rising-edge clock
//               RESET  - asynchronous active-high reset
//               DWR    - write data           ADDR - byte address
//               BE     - write byte enables   RD/WR - read / write request
//               ARDY   - request accepted when (RD|WR)&ARDY at an edge
//               DRD    - read data            DRDY - read data valid
// Revision    : 1.0 - initial release
// ============================================================================
module mi32_responder
  import mi32_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_BITS    = 4,
  parameter int          READ_LATENCY = 1,
  parameter int          WAIT_STATES  = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [MI32_DATA_W-1:0] DWR,
  input  logic [31:0]            ADDR,
  input  logic [MI32_BE_W-1:0]   BE,
  input  logic                   RD,
  input  logic                   WR,
  output logic                   ARDY,
  output logic [MI32_DATA_W-1:0] DRD,
  output logic                   DRDY
);

  localparam int          WORDS     = 1 << ADDR_BITS;
  localparam logic [31:0] ADDR_MASK = (32'd4 << ADDR_BITS) - 32'd1;
`ifdef MI32_RESP_WAIT_EN
  localparam bit          WAIT_EN   = 1'b1;
`else
  localparam bit          WAIT_EN   = 1'b0;
`endif
  localparam int          WS_EFF    = WAIT_EN ? WAIT_STATES : 0;

  logic                   req;
  logic                   accept;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   hit;
  logic [ADDR_BITS-1:0]   idx;
  logic [MI32_DATA_W-1:0] rd_word;

  assign req    = RD | WR;
  assign accept = req & ARDY;
  assign wr_acc = accept & WR;
  // RD together with WR is a write only.
  assign rd_acc = accept & RD & ~WR;
  assign hit    = (ADDR & ~ADDR_MASK) == BASE_ADDR;
  assign idx    = ADDR[ADDR_BITS+1:2];

  // --------------------------------------------------------------------------
  // Request acceptance
  // --------------------------------------------------------------------------
  generate
    if (WS_EFF == 0) begin : g_no_wait
      assign ARDY = req;
    end
`ifdef MI32_RESP_WAIT_EN
    else begin : g_wait
      wait_state_e state_q, state_d;
      logic [2:0]  wcnt_q, wcnt_d;
      logic        ardy_c;

      always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ardy_c  = 1'b0;
        case (state_q)
          WS_IDLE: begin
            if (req) begin
              wcnt_d  = 3'(WS_EFF - 1);
              state_d = WS_WAIT;
            end
          end
          WS_WAIT: begin
            if (!req) begin
              // Withdrawn request: restart the count for the next one.
              state_d = WS_IDLE;
            end else if (wcnt_q != 3'd0) begin
              wcnt_d = wcnt_q - 3'd1;
            end else begin
              ardy_c  = 1'b1;
              state_d = WS_IDLE;
            end
          end
          default: state_d = WS_IDLE;
        endcase
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          state_q <= WS_IDLE;
          wcnt_q  <= 3'd0;
        end else begin
          state_q <= state_d;
          wcnt_q  <= wcnt_d;
        end
      end

      assign ARDY = ardy_c;
    end
`endif
  endgenerate

  // --------------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------------
  logic [MI32_DATA_W-1:0] mem_q [WORDS];
  logic [MI32_DATA_W-1:0] mem_d [WORDS];

  always_comb begin
    mem_d = mem_q;
    if (wr_acc && hit) begin
      for (int b = 0; b < MI32_BE_W; b++) begin
        if (BE[b]) begin
          mem_d[idx][8*b +: 8] = DWR[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Sampled from the current array contents, so a write accepted on the same
  // or a later edge never disturbs data already captured for this read.
  assign rd_word = hit ? mem_q[idx] : MI32_MISS_DATA;

  // --------------------------------------------------------------------------
  // Read return pipeline
  // --------------------------------------------------------------------------
  mi32_resp_rdpipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .clk       (CLK),
    .rst       (RESET),
    .push_vld  (rd_acc),
    .push_data (rd_word),
    .drdy      (DRDY),
    .drd       (DRD)
  );

endmodule : mi32_responder
`default_nettype wire

// File: tb/tb_mi32_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mi32_responder
// Description : Scoreboard bench for mi32_responder. The driver queues the
//               expected data and acceptance cycle of each read; a monitor
//               pops and checks on every DRDY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mi32_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          AB   = 4;
  localparam int          LAT  = 3;
  localparam int          WS   = 3;
`ifdef MI32_RESP_WAIT_EN
  localparam int          EXP_WAIT = WS;
`else
  localparam int          EXP_WAIT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] DWR;
  logic [31:0] ADDR;
  logic [3:0]  BE;
  logic        RD;
  logic        WR;
  logic        ARDY;
  logic [31:0] DRD;
  logic        DRDY;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] exp_data [$];
  int          exp_cyc  [$];

  mi32_responder #(
    .BASE_ADDR    (BASE),
    .ADDR_BITS    (AB),
    .READ_LATENCY (LAT),
    .WAIT_STATES  (WS)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .DWR   (DWR),
    .ADDR  (ADDR),
    .BE    (BE),
    .RD    (RD),
    .WR    (WR),
    .ARDY  (ARDY),
    .DRD   (DRD),
    .DRDY  (DRDY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DRDY must match the oldest outstanding read.
  always @(negedge CLK) begin
    if (!RESET && DRDY) begin
      n_cmp++;
      if (exp_data.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_drdy: got DRD=%h with no read outstanding", DRD);
      end else begin
        logic [31:0] ed;
        int          ec;
        ed = exp_data.pop_front();
        ec = exp_cyc.pop_front();
        if (DRD !== ed || (cyc - ec) != LAT) begin
          n_bad++;
          $display("FAIL read_return: got DRD=%h latency=%0d expected DRD=%h latency=%0d",
                   DRD, cyc - ec, ed, LAT);
        end
      end
    end
  end

  // Present a request, wait for acceptance, check the wait-state count.
  task automatic req(input string nm, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp);
    int waited;
    RD = rd; WR = wr; ADDR = a; DWR = d; BE = be;
    waited = 0;
    forever begin
      @(negedge CLK);
      if (ARDY) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ARDY after %0d cycles expected ARDY", nm, waited);
    end else begin
      chk({nm, "_wait"}, waited, EXP_WAIT);
      if (rd && !wr) begin
        exp_data.push_back(exp);
        exp_cyc.push_back(cyc);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RD = 1'b0; WR = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; RD = 1'b0; WR = 1'b0; ADDR = '0; DWR = '0; BE = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ardy", ARDY, 1'b0);
    chk("rst_drdy", DRDY, 1'b0);
    chk("rst_drd",  DRD,  32'h0);
    @(posedge CLK); #3; RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle_ardy", ARDY, 1'b0);

    // Full write then read back
    req("w8",  0, 1, BASE + 32'h8, 32'hA5A5_0001, 4'hF, 0);
    req("r8",  1, 0, BASE + 32'h8, 32'h0, 4'h0, 32'hA5A5_0001);
    idle(1);

    // Byte-enable merge
    req("w0",  0, 1, BASE, 32'h1111_1111, 4'hF, 0);
    req("w0b", 0, 1, BASE, 32'hFFFF_FFFF, 4'b0101, 0);
    req("r0b", 1, 0, BASE, 32'h0, 4'h0, 32'h11FF_11FF);
    idle(1);

    // Words 0..3 = 0..3, then back-to-back reads
    for (int i = 0; i < 4; i++) req("wseq", 0, 1, BASE + 32'(4*i), 32'(i), 4'hF, 0);
    for (int i = 0; i < 4; i++) req("rseq", 1, 0, BASE + 32'(4*i), 32'h0, 4'hF, 32'(i));
    idle(1);

    // Address misses: just past the array, just below it, and a miss write
    req("rmiss_hi", 1, 0, BASE + 32'h40, 32'h0, 4'h0, 32'h0);
    req("rmiss_lo", 1, 0, BASE - 32'h4,  32'h0, 4'h0, 32'h0);
    req("wmiss",    0, 1, BASE + 32'h40, 32'hDEAD_BEEF, 4'hF, 0);
    req("r0_after", 1, 0, BASE,          32'h0, 4'h0, 32'h0);
    req("r1_alias", 1, 0, BASE + 32'h44, 32'h0, 4'h0, 32'h0);
    req("r1",       1, 0, BASE + 32'h4,  32'h0, 4'h0, 32'h1);
    idle(1);

    // RD and WR together act as a write with no read return
    req("rdwr",     1, 1, BASE + 32'h4, 32'h5555_5555, 4'hF, 0);
    req("r1_rdwr",  1, 0, BASE + 32'h4, 32'h0, 4'h0, 32'h5555_5555);
    idle(1);

    // Read-after-write, and a write inside an outstanding read's latency
    req("raw_w",    0, 1, BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 0);
    req("raw_r",    1, 0, BASE + 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D);
    req("wal_r",    1, 0, BASE + 32'hC, 32'h0, 4'h0, 32'h3);
    req("wal_w",    0, 1, BASE + 32'hC, 32'h7777_7777, 4'hF, 0);
    req("wal_r2",   1, 0, BASE + 32'hC, 32'h0, 4'h0, 32'h7777_7777);
    idle(LAT + 2);

    // Reset while a read is in flight: no DRDY, array cleared
    req("rst_rd",   1, 0, BASE + 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D);
    RD = 1'b0; WR = 1'b0;
    #2;
    RESET = 1'b1;
    exp_data.delete();
    exp_cyc.delete();
    #1;
    chk("midrst_drdy", DRDY, 1'b0);
    chk("midrst_drd",  DRD,  32'h0);
    @(posedge CLK); #3; RESET = 1'b0;
    idle(LAT + 1);
    req("post_r2",  1, 0, BASE + 32'h8, 32'h0, 4'h0, 32'h0);
    req("post_r3",  1, 0, BASE + 32'hC, 32'h0, 4'h0, 32'h0);
    idle(LAT + 3);

    chk("drain", exp_data.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mi32_responder
`default_nettype wire

// File: doc/mi32_responder.md
# mi32_responder

Synthesizable MI32 target (responder) terminating MI32 transactions from the software-side driver or a bus bridge. Holds a byte-writable register array at a fixed base address and returns read data in order with a fixed latency. It serves as the DUT-side endpoint for the MI32 verification components and as a generic config/status register block in hardware designs.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base address; must be aligned to the array size.
- ADDR_BITS, 4: log2 of the number of 32-bit words; legal range 1..6.
- READ_LATENCY, 1: number of cycles from read acceptance to DRDY; legal range 1..4.
- WAIT_STATES, 0: cycles ARDY is withheld per request; legal range 0..7. Used only with MI32_RESP_WAIT_EN.

Ports:
- CLK in 1: single clock; all logic is rising-edge.
- RESET in 1: asynchronous, active-high reset.
- DWR in 32: write data.
- ADDR in 32: byte address; bits [1:0] are ignored.
- BE in 4: write byte enables; BE[i] covers DWR[8i+7:8i].
- RD in 1: read request.
- WR in 1: write request.
- ARDY out 1: address ready. A request is accepted on an edge where (RD|WR)&ARDY.
- DRD out 32: read data, valid only while DRDY=1.
- DRDY out 1: read data valid, one cycle per accepted read.

## Operation

- Hit: (ADDR & ~(4*2^ADDR_BITS-1)) == BASE_ADDR. Word index = ADDR[ADDR_BITS+1:2].
- Accepted write, hit: each byte with BE[i]=1 is updated; other bytes are held. Miss: the write is discarded. Writes produce no DRDY.
- Accepted read: the word is sampled at the acceptance edge and pushed into the read pipeline. A miss pushes 32'h0. Reads ignore BE.
- RD and WR both high: treated as a write only. No read is pushed and no DRDY is produced.
- Read-after-write: a read accepted on the edge after a write to the same word returns the new data. A write accepted during a read's latency does not alter that read's data.
- No DRDY backpressure exists, so back-to-back reads produce consecutive DRDY pulses in acceptance order.
- Wait-state FSM (MI32_RESP_WAIT_EN, WAIT_STATES>0), states IDLE and WAIT:
  - IDLE, with RD|WR: ARDY=0, load wcnt=WAIT_STATES-1, go to WAIT.
  - WAIT, wcnt!=0: ARDY=0, decrement wcnt.
  - WAIT, wcnt==0: ARDY=RD|WR; on acceptance go to IDLE.
  - WAIT with RD=WR=0 (request withdrawn, illegal on MI32): return to IDLE.

## Timing

- Reset values: ARDY=0, DRDY=0, DRD=0, every array word 0, read pipeline empty, FSM in IDLE, wcnt=0.
- ARDY is combinational from RD/WR and FSM state. No wait states: ARDY=RD|WR in the same cycle.
- With wait states: a request first presented in cycle N is accepted in cycle N+WAIT_STATES. Each subsequent request repeats the full count.
- Read accepted at edge E: DRDY=1 and DRD valid in the cycle after edge E+READ_LATENCY-1, i.e. READ_LATENCY cycles later. DRDY lasts exactly one cycle.
- Throughput: one request per cycle with zero wait states. Otherwise one request per WAIT_STATES+1 cycles.
- RESET asserted mid-operation: all pending reads are dropped without DRDY, DRDY is forced to 0 immediately (asynchronously), the FSM returns to IDLE, and the array is cleared.

## Configuration

- MI32_RESP_WAIT_EN defined: the wait-state FSM and counter are built and WAIT_STATES applies.
- MI32_RESP_WAIT_EN undefined: no FSM, ARDY=RD|WR, and WAIT_STATES is ignored.

## Structure

- Package mi32_resp_pkg contains:
  - MI32_DATA_W=32 and MI32_BE_W=4;
  - MI32_MISS_DATA=32'h0;
  - the wait FSM state enum typedef;
  - a read-pipeline stage struct {logic vld; logic [31:0] data}.
- Sub-module mi32_resp_rdpipe: a READ_LATENCY-deep shift register of stage structs with asynchronous reset. It drives DRDY/DRD from its final stage.

## Test plan

- Write 32'hA5A5_0001 to BASE+0x8 with BE=4'hF, then read BASE+0x8 → with READ_LATENCY=2, DRDY two cycles after acceptance and DRD=32'hA5A5_0001.
- Write 32'h1111_1111 to BASE+0x0, then write 32'hFFFF_FFFF with BE=4'b0101, then read → DRD=32'h11FF_11FF.
- Four back-to-back reads of words 0..3 holding 0..3, READ_LATENCY=3 → four consecutive DRDY cycles, DRD=0,1,2,3, first DRDY 3 cycles after the first acceptance.
- WAIT_STATES=3 with the macro defined, continuous writes → ARDY high every 4th cycle; with the macro undefined, ARDY stays high continuously.
- Read at BASE+4*2^ADDR_BITS → DRDY with DRD=0. Write to that address, then read of word 0 → word 0 is unchanged.
- Read accepted, then RESET pulsed before DRDY → no DRDY appears; a following read of any word returns 0.
